// File: rtl/da2_voice_transmitter_if.sv
// Bus between the audio datapath and the PmodDA2 serial transmitter.
//   start, sample_a, sample_b : frame request and the two 12-bit samples
//   pd_mode                   : DAC power-down mode (only with DA2_PD_CTRL_EN)
//   sync_n, sclk, d0, d1      : DA2 serial pins
//   busy, done, overrun       : frame status
// master = datapath side (drives requests), slave = transmitter side.
interface da2_voice_transmitter_if;
    logic        start;
    logic [11:0] sample_a;
    logic [11:0] sample_b;
`ifdef DA2_PD_CTRL_EN
    logic [1:0]  pd_mode;
`endif
    logic        sync_n;
    logic        sclk;
    logic        d0;
    logic        d1;
    logic        busy;
    logic        done;
    logic        overrun;

`ifdef DA2_PD_CTRL_EN
    modport master (output start, sample_a, sample_b, pd_mode,
                    input  sync_n, sclk, d0, d1, busy, done, overrun);
    modport slave  (input  start, sample_a, sample_b, pd_mode,
                    output sync_n, sclk, d0, d1, busy, done, overrun);
`else
    modport master (output start, sample_a, sample_b,
                    input  sync_n, sclk, d0, d1, busy, done, overrun);
    modport slave  (input  start, sample_a, sample_b,
                    output sync_n, sclk, d0, d1, busy, done, overrun);
`endif
endinterface

// File: rtl/da2_voice_transmitter.sv
// PmodDA2 (dual DAC121S101) serial transmitter. One start strobe sends one
// 16-bit frame per channel, MSB first: {2'b00, pd[1:0], sample[11:0]}.
// Optional feature macro: DA2_PD_CTRL_EN adds bus.pd_mode, latched into
// bits 13:12 of both words; without it those bits are 00.
// Ports:
//   CLK  : system clock, all logic on posedge
//   RST  : synchronous active-high reset
//   bus  : da2_voice_transmitter_if.slave (start/samples in, DA2 pins and
//          busy/done/overrun status out; all outputs registered)
// Parameters:
//   SCLK_HALF  : CLK cycles per sclk half-period (2..1023)
//   GAP_CYCLES : CLK cycles sync_n stays high after a frame (1..1023)
module da2_voice_transmitter #(
    parameter int SCLK_HALF  = 50,
    parameter int GAP_CYCLES = 50
) (
    input  logic                         CLK,
    input  logic                         RST,
    da2_voice_transmitter_if.slave       bus
);

    localparam int HW = $clog2(SCLK_HALF);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [HW-1:0] H_LAST = HW'(SCLK_HALF - 1);
    localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LEAD, LOW, HIGH, GAP} state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    // Only the 15 not-yet-presented bits are kept; bit 15 goes straight
    // to d0/d1 on accept.
    logic [14:0]   sh_a_q, sh_a_d, sh_b_q, sh_b_d;
    logic          sync_n_q, sync_n_d, sclk_q, sclk_d;
    logic          d0_q, d0_d, d1_q, d1_d;
    logic          busy_q, busy_d, done_q, done_d, ovr_q, ovr_d;

    logic [1:0]    pd;
    logic [15:0]   word_a, word_b;

`ifdef DA2_PD_CTRL_EN
    assign pd = bus.pd_mode;
`else
    assign pd = 2'b00;
`endif

    assign word_a = {2'b00, pd, bus.sample_a};
    assign word_b = {2'b00, pd, bus.sample_b};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            hcnt_q   <= '0;
            gcnt_q   <= '0;
            bitcnt_q <= '0;
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            sync_n_q <= 1'b1;
            sclk_q   <= 1'b1;
            d0_q     <= 1'b0;
            d1_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hcnt_q   <= hcnt_d;
            gcnt_q   <= gcnt_d;
            bitcnt_q <= bitcnt_d;
            sh_a_q   <= sh_a_d;
            sh_b_q   <= sh_b_d;
            sync_n_q <= sync_n_d;
            sclk_q   <= sclk_d;
            d0_q     <= d0_d;
            d1_q     <= d1_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
        end
    end

    // Next-state and next-output logic. The registered outputs change on
    // the same edge as the state, so every pin is glitch-free.
    always_comb begin
        state_d  = state_q;
        hcnt_d   = hcnt_q + HW'(1);
        gcnt_d   = gcnt_q;
        bitcnt_d = bitcnt_q;
        sh_a_d   = sh_a_q;
        sh_b_d   = sh_b_q;
        sync_n_d = sync_n_q;
        sclk_d   = sclk_q;
        d0_d     = d0_q;
        d1_d     = d1_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ovr_d    = bus.start && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                hcnt_d = '0;
                if (bus.start) begin
                    state_d  = LEAD;
                    sh_a_d   = word_a[14:0];
                    sh_b_d   = word_b[14:0];
                    bitcnt_d = 4'd15;
                    sync_n_d = 1'b0;
                    sclk_d   = 1'b1;
                    d0_d     = word_a[15];
                    d1_d     = word_b[15];
                    busy_d   = 1'b1;
                end
            end
            LEAD: begin
                if (hcnt_q == H_LAST) begin
                    state_d = LOW;
                    hcnt_d  = '0;
                    sclk_d  = 1'b0;
                end
            end
            LOW: begin
                if (hcnt_q == H_LAST) begin
                    state_d = HIGH;
                    hcnt_d  = '0;
                    sclk_d  = 1'b1;
                end
            end
            HIGH: begin
                if (hcnt_q == H_LAST) begin
                    hcnt_d = '0;
                    if (bitcnt_q != 4'd0) begin
                        // New bit appears with the falling sclk and holds
                        // for the whole LOW phase.
                        state_d  = LOW;
                        sclk_d   = 1'b0;
                        d0_d     = sh_a_q[14];
                        d1_d     = sh_b_q[14];
                        sh_a_d   = {sh_a_q[13:0], 1'b0};
                        sh_b_d   = {sh_b_q[13:0], 1'b0};
                        bitcnt_d = bitcnt_q - 4'd1;
                    end else begin
                        state_d  = GAP;
                        gcnt_d   = '0;
                        sync_n_d = 1'b1;
                        d0_d     = 1'b0;
                        d1_d     = 1'b0;
                    end
                end
            end
            GAP: begin
                hcnt_d = '0;
                gcnt_d = gcnt_q + GW'(1);
                if (gcnt_q == G_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                hcnt_d  = '0;
            end
        endcase
    end

    assign bus.sync_n  = sync_n_q;
    assign bus.sclk    = sclk_q;
    assign bus.d0      = d0_q;
    assign bus.d1      = d1_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.overrun = ovr_q;

endmodule

// File: tb/tb_da2_voice_transmitter.sv
module tb_da2_voice_transmitter;

    localparam int H   = 2;
    localparam int G   = 2;
    localparam int LAT = 1 + 33 * H + G;

    logic CLK;
    logic RST;

    da2_voice_transmitter_if intf ();

    da2_voice_transmitter #(.SCLK_HALF(H), .GAP_CYCLES(G)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (intf)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
        logic [15:0] ea;
        logic [15:0] eb;
        bit          tog;
    } vec_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Frame monitor: samples pins on negedge, captures bits on each
    // observed sclk fall while sync_n is low, scores at the end of frame.
    bit          abort_frame = 1'b0;
    int          low_cnt = 0, fall_cnt = 0, n_done = 0, n_ovr = 0;
    logic [15:0] cap_a = '0, cap_b = '0;
    logic        prev_sclk = 1'b1, prev_sync = 1'b1;

    always @(negedge CLK) begin
        if (!intf.sync_n && prev_sync) begin
            low_cnt = 0; fall_cnt = 0; cap_a = '0; cap_b = '0;
        end
        if (!intf.sync_n) begin
            low_cnt++;
            if (prev_sclk && !intf.sclk) begin
                cap_a = {cap_a[14:0], intf.d0};
                cap_b = {cap_b[14:0], intf.d1};
                fall_cnt++;
            end
        end
        if (intf.sync_n && !prev_sync) begin
            if (abort_frame) begin
                abort_frame = 1'b0;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end else if (exp_q.size() == 0) begin
                chk("unexpected_frame", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("word_d0", {16'd0, cap_a}, {16'd0, e.a});
                chk("word_d1", {16'd0, cap_b}, {16'd0, e.b});
                chk("sync_low_cycles", low_cnt, 33 * H);
                chk("sclk_falls", fall_cnt, 16);
            end
        end
        if (intf.done)    n_done++;
        if (intf.overrun) n_ovr++;
        prev_sclk = intf.sclk;
        prev_sync = intf.sync_n;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Caller is at a negedge; accept happens at the next posedge.
    task automatic send(input logic [11:0] a, input logic [11:0] b,
                        input logic [15:0] ea, input logic [15:0] eb);
        exp_t e;
        intf.start = 1'b1;
        intf.sample_a = a;
        intf.sample_b = b;
        e.a = ea; e.b = eb;
        exp_q.push_back(e);
        @(negedge CLK);
        intf.start = 1'b0;
    endtask

    task automatic wait_done(input int lat0, input bit tog, input bit chk_lat);
        int lat;
        lat = lat0;
        while (!intf.done && lat < 400) begin
            @(negedge CLK);
            lat++;
            if (tog && lat == 30) begin
                intf.sample_a = ~intf.sample_a;
                intf.sample_b = ~intf.sample_b;
            end
        end
        if (chk_lat) chk("done_latency", lat, LAT);
        else         chk("done_seen", {31'd0, intf.done}, 32'd1);
    endtask

    vec_t vecs[5];
    int   exp_done = 0;
    int   snap;
    bit   bad;

    initial begin
        vecs[0] = '{12'hABC, 12'h123, 16'h0ABC, 16'h0123, 1'b0};
        vecs[1] = '{12'hFFF, 12'h000, 16'h0FFF, 16'h0000, 1'b1};
        vecs[2] = '{12'h000, 12'hFFF, 16'h0000, 16'h0FFF, 1'b1};
        vecs[3] = '{12'h555, 12'hAAA, 16'h0555, 16'h0AAA, 1'b0};
        vecs[4] = '{12'h800, 12'h001, 16'h0800, 16'h0001, 1'b0};

        intf.start = 1'b0;
        intf.sample_a = '0;
        intf.sample_b = '0;
`ifdef DA2_PD_CTRL_EN
        intf.pd_mode = 2'b00;
`endif
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst_outputs",
            {25'd0, intf.sync_n, intf.sclk, intf.d0, intf.d1, intf.busy, intf.done, intf.overrun},
            32'b1100000);
        RST = 1'b0;

        // Idle levels with no start
        bad = 1'b0;
        repeat (100) begin
            @(negedge CLK);
            if (intf.sync_n !== 1'b1 || intf.sclk !== 1'b1 || intf.d0 !== 1'b0 ||
                intf.d1 !== 1'b0 || intf.busy !== 1'b0) bad = 1'b1;
        end
        chk("idle_levels", {31'd0, bad}, 32'd0);

        // Table-driven frames
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            send(vecs[i].a, vecs[i].b, vecs[i].ea, vecs[i].eb);
            chk("accept_state", {29'd0, intf.sync_n, intf.busy, intf.sclk}, 32'b011);
            exp_done++;
            wait_done(1, vecs[i].tog, 1'b1);
            @(negedge CLK);
            chk("done_one_cycle", {30'd0, intf.done, intf.busy}, 32'd0);
        end

        // Overrun: second start 10 cycles after accept is ignored
        @(negedge CLK);
        send(12'hABC, 12'h123, 16'h0ABC, 16'h0123);
        exp_done++;
        repeat (9) @(negedge CLK);
        intf.start = 1'b1;
        intf.sample_a = 12'h111;
        intf.sample_b = 12'h222;
        @(negedge CLK);
        intf.start = 1'b0;
        chk("overrun_pulse", {31'd0, intf.overrun}, 32'd1);
        @(negedge CLK);
        chk("overrun_clear", {31'd0, intf.overrun}, 32'd0);
        wait_done(12, 1'b0, 1'b1);
        // start while done is high (block already back in IDLE)
        send(12'h456, 12'h789, 16'h0456, 16'h0789);
        exp_done++;
        chk("back_to_back_accept", {30'd0, intf.sync_n, intf.busy}, 32'b01);
        wait_done(1, 1'b0, 1'b1);

        // Reset mid-frame at bit 8
        @(negedge CLK);
        abort_frame = 1'b1;
        send(12'hAAA, 12'h555, 16'h0AAA, 16'h0555);
        snap = 0;
        while (fall_cnt < 8 && snap < 400) begin
            @(negedge CLK);
            snap++;
        end
        chk("reach_bit8", {31'd0, fall_cnt >= 8}, 32'd1);
        snap = n_done;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("midrst_outputs", {29'd0, intf.sync_n, intf.sclk, intf.busy}, 32'b110);
        repeat (100) @(negedge CLK);
        chk("midrst_no_done", n_done, snap);
        send(12'h3C5, 12'hA5A, 16'h03C5, 16'h0A5A);
        exp_done++;
        wait_done(1, 1'b0, 1'b1);

`ifdef DA2_PD_CTRL_EN
        @(negedge CLK);
        intf.pd_mode = 2'b11;
        send(12'h555, 12'h0F0, 16'h3555, 16'h30F0);
        intf.pd_mode = 2'b00;
        exp_done++;
        wait_done(1, 1'b0, 1'b1);
`endif

        repeat (5) @(negedge CLK);
        chk("queue_empty", exp_q.size(), 0);
        chk("done_count", n_done, exp_done);
        chk("overrun_count", n_ovr, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
